// File: rtl/sdm_pkg.sv
// Shared definitions for the 1-bit sigma-delta audio path (modulator and decimator).
// Holds PCM format constants and the common saturation helper.
package sdm_pkg;

    localparam int PCM_W     = 15;
    localparam int CIC_ORDER = 3;
    localparam int PCM_MAX   = 16383;
    localparam int PCM_MIN   = -16384;

    function automatic logic [PCM_W-1:0] sat_pcm(input logic signed [31:0] v);
        logic [PCM_W-1:0] res;
        if (v > PCM_MAX) begin
            res = PCM_W'(PCM_MAX);
        end else if (v < PCM_MIN) begin
            res = PCM_W'(PCM_MIN);
        end else begin
            res = v[PCM_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/cic3_chan.sv
// One channel of the sinc^3 decimator: integrators at the bit rate, combs at the
// decimated rate, then arithmetic scaling and saturation into a held PCM register.
module cic3_chan
    import sdm_pkg::*;
#(
    parameter int LOG2R = 6,
    parameter int ACCW  = 3 * LOG2R + 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_bit_en,
    input  logic             i_bit,
    input  logic             i_capture,
    input  logic             i_eval,
    input  logic             i_load,
    output logic [PCM_W-1:0] o_pcm
);

    localparam int SHIFT = CIC_ORDER * LOG2R - (PCM_W - 1);

    logic [ACCW-1:0]        w_x;
    logic [ACCW-1:0]        r_i1, r_i2, r_i3;
    logic [ACCW-1:0]        r_s;
    logic [ACCW-1:0]        r_d1, r_d2, r_d3;
    logic [ACCW-1:0]        w_c1, w_c2, w_c3;
    logic signed [ACCW-1:0] w_y;
    logic [PCM_W-1:0]       w_sat;
    logic [PCM_W-1:0]       r_pcm;

    assign w_x = i_bit ? {{(ACCW-1){1'b0}}, 1'b1} : {ACCW{1'b1}};

    // Integrators wrap freely; the combs cancel the wrap modulo 2^ACCW.
    assign w_c1  = r_s - r_d1;
    assign w_c2  = w_c1 - r_d2;
    assign w_c3  = w_c2 - r_d3;
    assign w_y   = $signed(w_c3) >>> SHIFT;
    assign w_sat = sat_pcm(32'(w_y));
    assign o_pcm = r_pcm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_i3  <= '0;
            r_s   <= '0;
            r_d1  <= '0;
            r_d2  <= '0;
            r_d3  <= '0;
            r_pcm <= '0;
        end else begin
            if (i_bit_en) begin
                r_i1 <= r_i1 + w_x;
                r_i2 <= r_i2 + r_i1;
                r_i3 <= r_i3 + r_i2;
                if (i_capture) begin
                    r_s <= r_i3 + r_i2;
                end
            end
            // Comb delays advance even during fill so the first loaded sample is clean.
            if (i_eval) begin
                r_d1 <= r_s;
                r_d2 <= w_c1;
                r_d3 <= w_c2;
                if (i_load) begin
                    r_pcm <= w_sat;
                end
            end
        end
    end

endmodule

// File: rtl/sdm_decimator.sv
// Stereo 1-bit sigma-delta demodulator: two sinc^3 channels sharing one decimation
// counter and one fill counter so both outputs stay sample-aligned.
module sdm_decimator
    import sdm_pkg::*;
#(
    parameter int LOG2R = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_en,
    input  logic             left_in,
    input  logic             right_in,
    output logic [PCM_W-1:0] ldata,
    output logic [PCM_W-1:0] rdata,
    output logic             valid,
    output logic             settled
);

    localparam int ACCW = 3 * LOG2R + 2;

    logic [LOG2R-1:0] r_cnt;
    logic [1:0]       r_fill;
    logic             r_cap;
    logic             r_valid;
    logic             r_settled;
    logic             w_capture;
    logic             w_load;

    assign w_capture = bit_en && (r_cnt == {LOG2R{1'b1}});
    assign w_load    = (r_fill == 2'd3);
    assign valid     = r_valid;
    assign settled   = r_settled;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_fill    <= '0;
            r_cap     <= 1'b0;
            r_valid   <= 1'b0;
            r_settled <= 1'b0;
        end else begin
            if (bit_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_cap   <= w_capture;
            r_valid <= 1'b0;
            // First three comb outputs only prime the delay line.
            if (r_cap) begin
                if (w_load) begin
                    r_valid   <= 1'b1;
                    r_settled <= 1'b1;
                end else begin
                    r_fill <= r_fill + 2'd1;
                end
            end
        end
    end

    cic3_chan #(
        .LOG2R(LOG2R),
        .ACCW (ACCW)
    ) u_left (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_bit_en (bit_en),
        .i_bit    (left_in),
        .i_capture(w_capture),
        .i_eval   (r_cap),
        .i_load   (w_load),
        .o_pcm    (ldata)
    );

    cic3_chan #(
        .LOG2R(LOG2R),
        .ACCW (ACCW)
    ) u_right (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_bit_en (bit_en),
        .i_bit    (right_in),
        .i_capture(w_capture),
        .i_eval   (r_cap),
        .i_load   (w_load),
        .o_pcm    (rdata)
    );

endmodule

// File: tb/tb_sdm_decimator.sv
// Directed bench for sdm_decimator: DC levels, periodic patterns, modulator loopback,
// bit_en gating and mid-stream reset.
module tb_sdm_decimator;

    logic        clk;
    logic        reset_n;
    logic        bit_en;
    logic        left_in;
    logic        right_in;
    logic [14:0] ldata;
    logic [14:0] rdata;
    logic        valid;
    logic        settled;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus generator state
    logic [3:0] pat_l   = 4'b1111;
    logic [3:0] pat_r   = 4'b1111;
    int         pidx    = 0;
    int         duty    = 1;
    int         ph      = 0;
    bit         hold    = 1'b0;
    bit         use_mod = 1'b0;
    int         acc_l   = 0;
    int         acc_r   = 0;
    int         pcm_l   = 0;
    int         pcm_r   = 0;

    sdm_decimator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bit_en  (bit_en),
        .left_in (left_in),
        .right_in(right_in),
        .ldata   (ldata),
        .rdata   (rdata),
        .valid   (valid),
        .settled (settled)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert (((obs - exp) <= tol) && ((exp - obs) <= tol))
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Drive one cycle of inputs, clock it in, return at the following negedge.
    task automatic step();
        logic en;
        en = !hold && (ph == 0);
        ph = (ph + 1) % duty;
        if (en) begin
            if (use_mod) begin
                left_in  = (acc_l >= 0);
                right_in = (acc_r >= 0);
                acc_l    = acc_l + pcm_l - (left_in ? 16384 : -16384);
                acc_r    = acc_r + pcm_r - (right_in ? 16384 : -16384);
            end else begin
                left_in  = pat_l[pidx];
                right_in = pat_r[pidx];
                pidx     = (pidx + 1) % 4;
            end
        end
        bit_en = en;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_strobe(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_n_strobes(input string tag, input int n);
        bit got;
        for (int i = 0; i < n; i++) begin
            wait_strobe(1000, got);
            if (!got) begin
                chk({tag, "_strobe_seen"}, 0, 1);
                break;
            end
        end
    endtask

    function automatic int sl();
        return int'($signed(ldata));
    endfunction

    function automatic int sr();
        return int'($signed(rdata));
    endfunction

    initial begin
        bit got;
        int t0;
        int t1;
        int s192;
        int nval;
        int first_at;

        reset_n  = 1'b0;
        bit_en   = 1'b0;
        left_in  = 1'b0;
        right_in = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_ldata", int'(ldata), 0);
        chk("reset_rdata", int'(rdata), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_settled", int'(settled), 0);

        // Constant 1: first valid in 1-based cycle 4*64+2 after bit_en rises.
        reset_n = 1'b1;
        cyc     = 0;
        s192    = -1;
        got     = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (cyc == 192) s192 = int'(settled);
            if (valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("ones_first_strobe_seen", int'(got), 1);
        chk("ones_not_settled_at_192", s192, 0);
        chk("ones_first_strobe_cycle", cyc + 1, 4 * 64 + 2);
        chk("ones_ldata", sl(), 16383);
        chk("ones_rdata", sr(), 16383);
        chk("ones_settled", int'(settled), 1);
        step();
        chk("ones_valid_one_cycle", int'(valid), 0);

        // Constant 0
        pat_l = 4'b0000;
        pat_r = 4'b0000;
        wait_n_strobes("zeros", 4);
        chk("zeros_ldata", sl(), -16384);
        chk("zeros_rdata", sr(), -16384);
        t0 = cyc;
        wait_strobe(200, got);
        chk("zeros_period", cyc - t0, 64);

        // Periodic patterns
        pat_l = 4'b1010;
        pat_r = 4'b1110;
        wait_n_strobes("pat1", 4);
        chk_tol("pat_alt_l", sl(), 0, 1);
        chk_tol("pat_1110_r", sr(), 8192, 1);
        pat_l = 4'b1000;
        pat_r = 4'b0101;
        wait_n_strobes("pat2", 4);
        chk_tol("pat_1000_l", sl(), -8192, 1);
        chk_tol("pat_alt_r", sr(), 0, 1);
        pat_l = 4'b0111;
        pat_r = 4'b0001;
        wait_n_strobes("pat3", 4);
        chk_tol("pat_0111_l", sl(), 8192, 1);
        chk_tol("pat_0001_r", sr(), -8192, 1);

        // Loopback through a first-order modulator model; 15'h6000 is -8192.
        use_mod = 1'b1;
        pcm_l   = 8191;
        pcm_r   = -8192;
        wait_n_strobes("loop1", 5);
        chk_tol("loop_1fff_l", sl(), 8191, 128);
        chk_tol("loop_6000_r", sr(), -8192, 128);
        pcm_l = -8192;
        pcm_r = 8191;
        wait_n_strobes("loop2", 5);
        chk_tol("loop_6000_l", sl(), -8192, 128);
        chk_tol("loop_1fff_r", sr(), 8191, 128);
        pcm_l = 0;
        pcm_r = 0;
        wait_n_strobes("loop3", 5);
        chk_tol("loop_zero_l", sl(), 0, 128);
        chk_tol("loop_zero_r", sr(), 0, 128);
        use_mod = 1'b0;

        // bit_en at 1-in-3 duty, constant 1
        pat_l = 4'b1111;
        pat_r = 4'b1111;
        duty  = 3;
        ph    = 0;
        wait_n_strobes("gate", 4);
        t0 = cyc;
        wait_strobe(400, got);
        t1 = cyc;
        chk("gate_period", t1 - t0, 192);
        chk("gate_ldata", sl(), 16383);
        chk("gate_rdata", sr(), 16383);

        // Hold bit_en low with a capture just taken: only that one strobe may follow.
        duty = 1;
        ph   = 0;
        wait_strobe(400, got);
        repeat (63) step();
        hold     = 1'b1;
        nval     = 0;
        first_at = -1;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (valid) begin
                nval++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("hold_strobe_count", nval, 1);
        chk("hold_inflight_at", first_at, 1);
        chk("hold_ldata_kept", sl(), 16383);
        hold = 1'b0;

        // Mid-stream reset
        wait_strobe(400, got);
        repeat (20) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_ldata", int'(ldata), 0);
        chk("midrst_rdata", int'(rdata), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_settled", int'(settled), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pidx    = 0;
        cyc     = 0;
        wait_strobe(400, got);
        chk("midrst_strobe_seen", int'(got), 1);
        chk("midrst_first_strobe_cycle", cyc + 1, 4 * 64 + 2);
        chk("midrst_ldata", sl(), 16383);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdm_decimator.md
Name: sdm_decimator

Overview:
- Stereo 1-bit sigma-delta demodulator: the receive-side counterpart of the audio sdm modulator.
- Each channel is a 3rd-order CIC (sinc^3) decimator. It turns a 1-bit density stream back into 15-bit signed PCM with a one-cycle valid strobe.
- Used for audio loopback checking of the sdm output path in the audio subsystem.
- Also used as a PCM front end for external 1-bit (PDM) audio sources.

Parameters:
- LOG2R, 6, log2 of the decimation ratio R (R=64). Legal range 5..8.
- ACCW, 3*LOG2R+2, internal accumulator width. Derived; must not be overridden.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- bit_en  in  1  sample enable; left_in/right_in are consumed only on cycles where it is high
- left_in  in  1  left 1-bit stream; 1 = +1, 0 = -1
- right_in  in  1  right 1-bit stream; 1 = +1, 0 = -1
- ldata  out  15  left PCM, signed two's complement
- rdata  out  15  right PCM, signed two's complement
- valid  out  1  one-cycle strobe when ldata/rdata update
- settled  out  1  high once the filter pipeline has been filled after reset

Behaviour:
- Reset (async assert, sync-safe deassert on clk):
  - integrators, comb delay registers, decimation counter and fill counter = 0
  - ldata = rdata = 0; valid = 0; settled = 0
- Input mapping: x = +1 when the bit is 1, x = -1 when it is 0. x is sign-extended to ACCW.
- Integrators, three cascaded per channel, updated only on bit_en:
  - I1 += x; I2 += I1; I3 += I2
  - All ACCW-bit two's complement. Wrap-around is intentional and must not saturate; the combs cancel it.
- Decimation counter:
  - LOG2R bits, increments on each bit_en and wraps naturally.
  - On the bit_en cycle where counter == R-1, the post-update I3 value is captured as decimated sample s.
- Combs, evaluated in the cycle after capture, three cascaded, each with one delay register:
  - C1 = s - D1; D1 <= s
  - C2 = C1 - D2; D2 <= C1
  - C3 = C2 - D3; D3 <= C2
  - Arithmetic is modulo 2^ACCW.
- Gain and scaling:
  - DC gain is R^3 = 2^(3*LOG2R), so the |C3| maximum is 2^(3*LOG2R).
  - y = C3 >>> (3*LOG2R - 14), arithmetic shift.
  - Saturate y to [-16384, +16383]. All-ones input gives +16384, which must clamp to +16383.
- Output timing:
  - ldata/rdata are registered.
  - valid pulses high for exactly 1 cycle, 2 clk cycles after the capturing bit_en cycle.
  - Both channels update together.
  - Outputs hold their value between strobes.
- Settling:
  - A 2-bit fill counter counts decimated samples.
  - The first 3 comb outputs after reset are transients: valid stays low for them and ldata/rdata stay 0.
  - From the 4th decimated sample on, settled = 1 and valid strobes normally.
  - settled stays high until the next reset.
- bit_en low:
  - Integrators, counter and combs all freeze.
  - A comb/output evaluation already in flight still completes, so valid may fire after bit_en drops.
- bit_en continuously high: one output every R clk cycles.
- Reset mid-operation: all state is cleared immediately, and settling restarts from scratch.

Decomposition:
- Shared package sdm_pkg holds:
  - PCM_W = 15
  - CIC_ORDER = 3
  - PCM_MAX = 16383
  - PCM_MIN = -16384
  - the saturation function, shared with sdm
- Sub-module cic3_chan holds one channel's integrators, combs, shift and saturation. It is instantiated twice.
- The decimation counter and fill counter live in the top level and are shared by both channels, so L and R stay sample-aligned.

Test Plan:
- Reset, then constant 1 on both inputs with bit_en high:
  - Required: valid low for the first 3*64 cycles.
  - Required: the first strobe at cycle 4*64+2 with ldata = rdata = 16383, settled = 1.
- Constant 0:
  - Required: settled outputs = -16384.
  - Required: valid period exactly 64 cycles.
- Patterns, after settling:
  - alternating 1010...: outputs 0.
  - 1110 repeating: outputs +8192.
  - 1000 repeating: outputs -8192.
  - Tolerance ±1 LSB.
- Loopback: feed the sdm modulator outputs into left_in/right_in.
  - PCM 15'h1fff must decode to 8191 ±128.
  - PCM 15'h6000 must decode to -8192 ±128.
  - PCM 0 must decode to 0 ±128.
  - Check both channels.
- bit_en gating at a 1-in-3 duty with constant 1:
  - Required: valid period is 192 clk cycles.
  - Required: settled value is 16383.
  - Required: no valid strobe while bit_en is held low for 1000 cycles, other than a strobe already in flight.
- Assert reset_n low mid-stream, between two strobes:
  - Required: ldata/rdata/valid/settled go to 0 immediately.
  - Required: after release, 3 suppressed samples occur again before the first valid.
